// File: rtl/alu_pkg.sv
// Types and constants shared by the ALU shifter and the sequential normalizer.
package alu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic NORM_UNSIGNED = 1'b0;
  localparam logic NORM_SIGNED   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } norm_state_t;

endpackage

// File: rtl/seq_normalizer_if.sv
// Operand/result handshake bundle for seq_normalizer.
// The signed_mode wire exists only when SEQ_NORM_SIGNED_EN is defined.
interface seq_normalizer_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int SHIFT_AMOUNT_WIDTH = $clog2(DATA_WIDTH)
);
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [SHIFT_AMOUNT_WIDTH-1:0] shift_count;
  logic                          zero;
`ifdef SEQ_NORM_SIGNED_EN
  logic                          signed_mode;
`endif

  modport master (
    output in_valid, in_data, out_ready,
`ifdef SEQ_NORM_SIGNED_EN
    output signed_mode,
`endif
    input  in_ready, out_valid, out_data, shift_count, zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef SEQ_NORM_SIGNED_EN
    input  signed_mode,
`endif
    output in_ready, out_valid, out_data, shift_count, zero
  );
endinterface

// File: rtl/seq_normalizer_norm_detect.sv
// norm_detect: combinational "is this value normalized" test for unsigned
// (MSB set) or signed (top two bits differ) interpretation.
module norm_detect
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  mode,
  output logic                  is_normalized
);

  always_comb begin
    if (mode == NORM_SIGNED) is_normalized = value[DATA_WIDTH-1] ^ value[DATA_WIDTH-2];
    else                     is_normalized = value[DATA_WIDTH-1];
  end

endmodule

// File: rtl/seq_normalizer.sv
// Iterative left-normalizer: one shift per clock, returns the normalized value
// and the shift amount. Signed normalization is built in with SEQ_NORM_SIGNED_EN.
module seq_normalizer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int SHIFT_AMOUNT_WIDTH = $clog2(DATA_WIDTH)
) (
  input logic          clk,
  input logic          rst_n,
  seq_normalizer_if.slave bus
);

  norm_state_t                   state, state_d;
  logic [DATA_WIDTH-1:0]         work, work_d;
  logic [SHIFT_AMOUNT_WIDTH-1:0] count, count_d;
  logic                          zero_q, zero_d;
  logic                          mode_now;
  logic                          is_norm;

`ifdef SEQ_NORM_SIGNED_EN
  logic mode_q, mode_d;
  assign mode_now = mode_q;
`else
  assign mode_now = NORM_UNSIGNED;
`endif

  norm_detect #(.DATA_WIDTH(DATA_WIDTH)) u_detect (
    .value         (work),
    .mode          (mode_now),
    .is_normalized (is_norm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      count  <= '0;
      zero_q <= 1'b0;
`ifdef SEQ_NORM_SIGNED_EN
      mode_q <= NORM_UNSIGNED;
`endif
    end else begin
      state  <= state_d;
      work   <= work_d;
      count  <= count_d;
      zero_q <= zero_d;
`ifdef SEQ_NORM_SIGNED_EN
      mode_q <= mode_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    work_d  = work;
    count_d = count;
    zero_d  = zero_q;
`ifdef SEQ_NORM_SIGNED_EN
    mode_d  = mode_q;
`endif
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_data;
          count_d = '0;
`ifdef SEQ_NORM_SIGNED_EN
          mode_d  = bus.signed_mode;
`endif
          // A zero operand can never normalize, so skip straight to the result.
          if (bus.in_data == '0) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            zero_d  = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (is_norm) begin
          state_d = DONE;
        end else begin
          work_d  = {work[DATA_WIDTH-2:0], 1'b0};
          count_d = count + SHIFT_AMOUNT_WIDTH'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.out_data    = work;
  assign bus.shift_count = count;
  assign bus.zero        = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer: directed vector table, multi-cycle
// corner sequences and randomized operands against a behavioural model.
module tb_seq_normalizer;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int SW = $clog2(W);

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seq_normalizer_if #(.DATA_WIDTH(W)) bus ();

  seq_normalizer #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    bit           smode;
    logic [W-1:0] exp_out;
    int           exp_cnt;
    bit           exp_zero;
    int           exp_lat;
  } vec_t;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: count leading zeros (unsigned) or redundant sign bits (signed).
  function automatic void model(input logic [W-1:0] d, input bit s,
                                output logic [W-1:0] o, output int c, output bit z);
    int msb;
    int run;
    z = (d == '0);
    c = 0;
    if (!z) begin
      if (!s) begin
        msb = 0;
        for (int i = 0; i < W; i++) if (d[i]) msb = i;
        c = W - 1 - msb;
      end else begin
        run = 1;
        while (run < W && d[W-1-run] == d[W-1]) run++;
        c = run - 1;
      end
    end
    o = d << c;
  endfunction

  task automatic set_mode(input bit s);
`ifdef SEQ_NORM_SIGNED_EN
    bus.signed_mode = s;
`endif
  endtask

  // One full transaction; starts and ends just after a falling edge.
  task automatic run_op(input string name, input logic [W-1:0] data, input bit smode,
                        input int hold, input logic [W-1:0] exp_out, input int exp_cnt,
                        input bit exp_zero, input int exp_lat, input bit keep_valid,
                        input logic [W-1:0] next_data);
    int w;
    int edges;
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    set_mode(smode);
    bus.out_ready = (hold == 0);
    w = 0;
    while (!bus.in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({name, " accept_timeout"}, bus.in_ready, 1);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.in_valid = keep_valid;
    bus.in_data  = next_data;
    set_mode(~smode);
    while (!bus.out_valid && edges < 40) begin
      check({name, " busy_in_ready"}, bus.in_ready, 0);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({name, " out_valid"}, bus.out_valid, 1);
    check({name, " latency"}, edges, exp_lat);
    check({name, " out_data"}, bus.out_data, exp_out);
    check({name, " shift_count"}, bus.shift_count, exp_cnt);
    check({name, " zero"}, bus.zero, exp_zero);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, " hold_valid"}, bus.out_valid, 1);
      check({name, " hold_in_ready"}, bus.in_ready, 0);
      check({name, " hold_data"}, bus.out_data, exp_out);
      check({name, " hold_count"}, bus.shift_count, exp_cnt);
      check({name, " hold_zero"}, bus.zero, exp_zero);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({name, " release_valid"}, bus.out_valid, 0);
    check({name, " release_in_ready"}, bus.in_ready, 1);
    bus.out_ready = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] m_out;
    int           m_cnt;
    bit           m_zero;
    logic [W-1:0] rd;
    bit           rs;

    vecs.push_back('{8'h01, 1'b0, 8'h80, 7, 1'b0, 9});
    vecs.push_back('{8'h00, 1'b0, 8'h00, 0, 1'b1, 1});
    vecs.push_back('{8'h80, 1'b0, 8'h80, 0, 1'b0, 2});
    vecs.push_back('{8'h3C, 1'b0, 8'hF0, 2, 1'b0, 4});
    vecs.push_back('{8'hFF, 1'b0, 8'hFF, 0, 1'b0, 2});
    vecs.push_back('{8'h10, 1'b0, 8'h80, 3, 1'b0, 5});
`ifdef SEQ_NORM_SIGNED_EN
    vecs.push_back('{8'hF8, 1'b1, 8'h80, 4, 1'b0, 6});
    vecs.push_back('{8'h03, 1'b1, 8'h60, 5, 1'b0, 7});
    vecs.push_back('{8'hFF, 1'b1, 8'h80, 7, 1'b0, 9});
    vecs.push_back('{8'h40, 1'b1, 8'h40, 0, 1'b0, 2});
    vecs.push_back('{8'hBF, 1'b1, 8'hBF, 0, 1'b0, 2});
    vecs.push_back('{8'h00, 1'b1, 8'h00, 0, 1'b1, 1});
`endif

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    set_mode(1'b0);
    #12;
    check("reset in_ready", bus.in_ready, 1);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_data", bus.out_data, 0);
    check("reset shift_count", bus.shift_count, 0);
    check("reset zero", bus.zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].smode, 0, vecs[i].exp_out,
             vecs[i].exp_cnt, vecs[i].exp_zero, vecs[i].exp_lat, 1'b0, 8'hA5);

    run_op("hold80", 8'h80, 1'b0, 5, 8'h80, 0, 1'b0, 2, 1'b0, 8'h5A);

    // Reset in the middle of shifting 0x01.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    set_mode(1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", bus.out_valid, 0);
    check("midrst in_ready", bus.in_ready, 1);
    check("midrst out_data", bus.out_data, 0);
    check("midrst shift_count", bus.shift_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst20", 8'h20, 1'b0, 0, 8'h80, 2, 1'b0, 4, 1'b0, 8'h00);

    // Back-to-back with in_valid held high; second operand waits for the handshake.
    run_op("b2b_first", 8'h10, 1'b0, 2, 8'h80, 3, 1'b0, 5, 1'b1, 8'h04);
    run_op("b2b_second", 8'h04, 1'b0, 0, 8'h80, 5, 1'b0, 7, 1'b0, 8'h00);

    for (int n = 0; n < 200; n++) begin
      rd = W'($urandom) >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 9) == 0) rd = '0;
`ifdef SEQ_NORM_SIGNED_EN
      rs = bit'($urandom_range(0, 1));
      if (rs && $urandom_range(0, 1) == 1) rd = ~rd;
`else
      rs = 1'b0;
`endif
      model(rd, rs, m_out, m_cnt, m_zero);
      run_op($sformatf("rnd%0d_%02h", n, rd), rd, rs, $urandom_range(0, 2), m_out, m_cnt,
             m_zero, m_zero ? 1 : m_cnt + 2, 1'b0, W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
